cdb_arbiter: RTL and testbench

Arbitrates the single Common Data Bus among the execution-unit result ports of the out-of-order core. At most one result is granted per cycle, and its tag and data are broadcast on a registered CDB. The register status table, the reservation stations and the register file consume that broadcast to clear tags and capture operands. Each requester holds its result until it is granted, so results are never dropped.

---
 rtl/cdb_pkg.sv | 31 +++
 rtl/cdb_arbiter_if.sv | 39 +++
 rtl/cdb_arbiter_rr_picker.sv | 36 +++
 rtl/cdb_arbiter.sv | 117 +++++++++++
 tb/tb_cdb_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
//----------------------------------------------------------------------------
// Module : cdb_pkg
// Shared Common Data Bus widths, broadcast record and execution port indices.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

package cdb_pkg;

    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 32;

    localparam int CDB_PORT_LS  = 0;
    localparam int CDB_PORT_INT = 1;
    localparam int CDB_PORT_MUL = 2;
    localparam int CDB_PORT_DIV = 3;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_bus_t;

    // Width of a port index; a 1-bit field is kept even for degenerate counts.
    function automatic int cdb_src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
//----------------------------------------------------------------------------
// Module : cdb_arbiter_if
// Result-port request bundle and registered CDB broadcast of the arbiter.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int SRC_W   = cdb_src_w(NUM_REQ)
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [SRC_W-1:0]          cdb_src;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

endinterface

`default_nettype wire

// File: rtl/cdb_arbiter_rr_picker.sv
//----------------------------------------------------------------------------
// Module : rr_picker
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module rr_picker
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = cdb_src_w(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req_i,
    input  wire logic [PTR_W-1:0]   ptr_i,
    output logic      [NUM_REQ-1:0] grant_o
);

    localparam int DBL_W = 2 * NUM_REQ;

    logic [NUM_REQ-1:0] w_mask;
    logic [DBL_W-1:0]   w_dbl;
    logic [DBL_W-1:0]   w_iso;

    // Lower copy holds only requests at or above the pointer, upper copy holds
    // all of them, so the lowest set bit of the pair is the wrapped winner.
    always_comb begin
        w_mask  = ~((NUM_REQ'(1) << ptr_i) - NUM_REQ'(1));
        w_dbl   = {req_i, req_i & w_mask};
        w_iso   = w_dbl & (~w_dbl + DBL_W'(1));
        grant_o = w_iso[NUM_REQ-1:0] | w_iso[DBL_W-1:NUM_REQ];
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
//----------------------------------------------------------------------------
// Module : cdb_arbiter
// Grants one result port per cycle onto the registered Common Data Bus.
// Build  : define CDB_ARB_RR_EN for round-robin, otherwise fixed priority.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W
) (
    input  wire logic    clk,
    input  wire logic    rst,
    cdb_arbiter_if.slave cdb_if
);

    localparam int SRC_W = cdb_src_w(NUM_REQ);

    logic [NUM_REQ-1:0] w_pick;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_grant_any;
    logic [SRC_W-1:0]   w_grant_idx;
    logic [TAG_W-1:0]   w_sel_tag;
    logic [DATA_W-1:0]  w_sel_data;

    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q,  cdb_data_d;
    logic [SRC_W-1:0]   cdb_src_q,   cdb_src_d;

`ifdef CDB_ARB_RR_EN
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (SRC_W)
    ) u_rr_picker (
        .req_i   (cdb_if.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (w_pick)
    );

    // Pointer moves just past the winner; explicit wrap covers non-power-of-two counts.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_grant_any) begin
            rr_ptr_d = (w_grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign w_pick = cdb_if.req_valid & (~cdb_if.req_valid + NUM_REQ'(1));
`endif

    assign w_grant          = rst ? '0 : w_pick;
    assign w_grant_any      = |w_grant;
    assign cdb_if.req_ready = w_grant;

    // One-hot grant drives an AND-OR mux, so no index arithmetic on the data path.
    always_comb begin
        w_grant_idx = '0;
        w_sel_tag   = '0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = SRC_W'(i);
            end
            w_sel_tag  = w_sel_tag  | ({TAG_W{w_grant[i]}}  & cdb_if.req_tag[i*TAG_W +: TAG_W]);
            w_sel_data = w_sel_data | ({DATA_W{w_grant[i]}} & cdb_if.req_data[i*DATA_W +: DATA_W]);
        end
    end

    always_comb begin
        cdb_valid_d = w_grant_any;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (w_grant_any) begin
            cdb_tag_d  = w_sel_tag;
            cdb_data_d = w_sel_data;
            cdb_src_d  = w_grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_if.cdb_valid = cdb_valid_q;
    assign cdb_if.cdb_tag   = cdb_tag_q;
    assign cdb_if.cdb_data  = cdb_data_q;
    assign cdb_if.cdb_src   = cdb_src_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
//----------------------------------------------------------------------------
// Module : tb_cdb_arbiter
// Self-checking bench for cdb_arbiter (either CDB_ARB_RR_EN build).
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N  = 4;
    localparam int TW = CDB_TAG_W;
    localparam int DW = CDB_DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) cdb_if ();

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .cdb_if (cdb_if)
    );

    logic [N-1:0]  valid;
    logic [TW-1:0] tags  [N];
    logic [DW-1:0] datas [N];

    always_comb begin
        cdb_if.req_valid = valid;
        cdb_if.req_tag   = '0;
        cdb_if.req_data  = '0;
        for (int i = 0; i < N; i++) begin
            cdb_if.req_tag[i*TW +: TW]  = tags[i];
            cdb_if.req_data[i*DW +: DW] = datas[i];
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference: pointer as a plain integer, broadcast as the package record.
    int       m_ptr;
    cdb_bus_t m_bus;
    int       m_src;
    logic [N-1:0] s_ready;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v);
`ifdef CDB_ARB_RR_EN
        for (int j = 0; j < N; j++) if (v[(m_ptr + j) % N]) return (m_ptr + j) % N;
`else
        for (int j = 0; j < N; j++) if (v[j]) return j;
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] r;
        r = '0;
        if (k >= 0) r[k] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_bus = '0;
        m_src = 0;
    endtask

    // Entered just after a rising edge with inputs already driven.
    task automatic cycle(input string nm, output int k);
        #3;
        s_ready = cdb_if.req_ready;
        k = model_pick(valid);
        check({nm, ".ready"}, 64'(s_ready), 64'(onehot(k)));
        @(posedge clk);
        if (k >= 0) begin
            m_bus = '{1'b1, tags[k], datas[k]};
            m_src = k;
            m_ptr = (k + 1) % N;
        end else begin
            m_bus.valid = 1'b0;
        end
        #1;
        check({nm, ".cdb_valid"}, 64'(cdb_if.cdb_valid), 64'(m_bus.valid));
        check({nm, ".cdb_tag"},   64'(cdb_if.cdb_tag),   64'(m_bus.tag));
        check({nm, ".cdb_data"},  64'(cdb_if.cdb_data),  64'(m_bus.data));
        check({nm, ".cdb_src"},   64'(cdb_if.cdb_src),   64'(m_src));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("rst.ready",     64'(cdb_if.req_ready), 64'(0));
        check("rst.cdb_valid", 64'(cdb_if.cdb_valid), 64'(0));
        check("rst.cdb_tag",   64'(cdb_if.cdb_tag),   64'(0));
        check("rst.cdb_data",  64'(cdb_if.cdb_data),  64'(0));
        check("rst.cdb_src",   64'(cdb_if.cdb_src),   64'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0]  v;
        logic [TW-1:0] tbase;
        logic [DW-1:0] dbase;
        logic [N-1:0]  rdy;
        logic          cv;
        logic [TW-1:0] tg;
        logic [DW-1:0] dt;
        int            src;
    } vec_t;

    vec_t tbl [6];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int k;
        int exp_cont [5];
        int exp_fix  [4];

        // Port i carries tag tbase+i and data dbase+i.
        tbl[0] = '{4'b0100, 6'h13, 32'hDEADBEED, 4'b0100, 1'b1, 6'h15, 32'hDEADBEEF, 2};
        tbl[1] = '{4'b1111, 6'h20, 32'h10000000, 4'b0001, 1'b1, 6'h20, 32'h10000000, 0};
        tbl[2] = '{4'b1010, 6'h08, 32'h000000A0, 4'b0010, 1'b1, 6'h09, 32'h000000A1, 1};
        tbl[3] = '{4'b1000, 6'h3D, 32'hFFFFFFFD, 4'b1000, 1'b1, 6'h00, 32'h00000000, 3};
        tbl[4] = '{4'b0110, 6'h01, 32'h00000005, 4'b0010, 1'b1, 6'h02, 32'h00000006, 1};
        tbl[5] = '{4'b0000, 6'h11, 32'h12345678, 4'b0000, 1'b0, 6'h00, 32'h00000000, 0};

`ifdef CDB_ARB_RR_EN
        exp_cont = '{0, 1, 2, 3, 0};
        exp_fix  = '{1, 3, 1, 3};
`else
        exp_cont = '{0, 0, 0, 0, 0};
        exp_fix  = '{1, 1, 1, 1};
`endif

        valid = '1;
        for (int i = 0; i < N; i++) begin
            tags[i]  = TW'(i + 1);
            datas[i] = DW'(32'hA000 + i);
        end
        model_reset();
        do_reset();

        for (int e = 0; e < 6; e++) begin
            do_reset();
            valid = tbl[e].v;
            for (int i = 0; i < N; i++) begin
                tags[i]  = tbl[e].tbase + TW'(i);
                datas[i] = tbl[e].dbase + DW'(i);
            end
            cycle("vec", k);
            check("vec.tbl_ready", 64'(s_ready),           64'(tbl[e].rdy));
            check("vec.tbl_valid", 64'(cdb_if.cdb_valid),  64'(tbl[e].cv));
            check("vec.tbl_tag",   64'(cdb_if.cdb_tag),    64'(tbl[e].tg));
            check("vec.tbl_data",  64'(cdb_if.cdb_data),   64'(tbl[e].dt));
            check("vec.tbl_src",   64'(cdb_if.cdb_src),    64'(tbl[e].src));
        end

        // All ports continuously valid.
        do_reset();
        valid = '1;
        for (int c = 0; c < 5; c++) begin
            cycle("cont", k);
            check("cont.grant", 64'(s_ready), 64'(onehot(exp_cont[c])));
            check("cont.src",   64'(cdb_if.cdb_src), 64'(exp_cont[c]));
            check("cont.valid", 64'(cdb_if.cdb_valid), 64'(1));
        end

        // Grant port 3, idle, then ports 0 and 3.
        do_reset();
        valid = 4'b1000;
        cycle("wrap", k);
        check("wrap.g3", 64'(s_ready), 64'(4'b1000));
        valid = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            cycle("idle", k);
            check("idle.valid", 64'(cdb_if.cdb_valid), 64'(0));
            check("idle.src",   64'(cdb_if.cdb_src),   64'(3));
        end
        valid = 4'b1001;
        cycle("wrap2", k);
        check("wrap2.g0", 64'(s_ready), 64'(4'b0001));
        valid = 4'b1000;
        cycle("wrap3", k);
        check("wrap3.g3", 64'(s_ready), 64'(4'b1000));

        // Ports 1 and 3 continuously valid.
        do_reset();
        valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            cycle("fix", k);
            check("fix.grant", 64'(s_ready), 64'(onehot(exp_fix[c])));
        end

        // Reset pulsed while port 1 is being granted with ports 2 and 3 pending.
        do_reset();
        valid = 4'b1110;
        cycle("mid", k);
        check("mid.g1", 64'(s_ready), 64'(4'b0010));
        #1;
        rst = 1'b1;
        #1;
        check("mid.rst_valid", 64'(cdb_if.cdb_valid), 64'(0));
        check("mid.rst_ready", 64'(cdb_if.req_ready), 64'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        valid = 4'b1100;
        cycle("mid2", k);
        check("mid2.g2",  64'(s_ready),        64'(4'b0100));
        check("mid2.src", 64'(cdb_if.cdb_src), 64'(2));

        // Random traffic: requesters hold their result until granted.
        do_reset();
        valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid[i] && $urandom_range(0, 99) < 45) begin
                    valid[i] = 1'b1;
                    tags[i]  = TW'($urandom);
                    datas[i] = $urandom;
                end
            end
            if (c == 200) do_reset();
            cycle("rand", k);
            if (k >= 0) valid[k] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
